// File: rtl/pi_master_if.sv
// User-side request/data bus and SPI pins of pi_master.
// The master modport is the view taken by pi_master; slave is the user/SPI-slave side.
interface pi_master_if #(
    parameter int LEN_W = 16
);
    logic             req;
    logic             we;
    logic [6:0]       cmd;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [7:0]       wr_data;
    logic             wr_ack;
    logic [7:0]       rd_data;
    logic             rd_vld;
    logic             spi_sck;
    logic             spi_ss;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        input  req, we, cmd, addr, len, wr_data, spi_miso,
        output busy, done, wr_ack, rd_data, rd_vld, spi_sck, spi_ss, spi_mosi
    );

    modport slave (
        output req, we, cmd, addr, len, wr_data, spi_miso,
        input  busy, done, wr_ack, rd_data, rd_vld, spi_sck, spi_ss, spi_mosi
    );
endinterface

// File: rtl/pi_master.sv
// SPI mode-0 master issuing PI bus transactions: {we,cmd}, 24-bit address,
// optional read turnaround bytes, then len data bytes streamed to/from the user side.
module pi_master #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 16,
    parameter int TURN    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    pi_master_if.master bus
);
    localparam int               CW        = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]    CW_ONE    = CW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] ADDR_LAST = LEN_W'(2);
    localparam logic [LEN_W-1:0] TURN_LAST = (TURN > 0) ? LEN_W'(TURN - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_TURN, S_DATA, S_END, S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    div_cnt;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt, cnt_nxt, len_q;
    logic [23:0]      addr_q;
    logic             we_q;
    logic [6:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic [7:0]       nxt_byte;
    logic [7:0]       rd_data_r;
    logic             sck, ss, mosi, done_r, rd_vld_r;
    logic             shifting, tick, rise, fall, byte_end, accept, go_data, wr_ack_c;

    assign shifting = state inside {S_CMD, S_ADDR, S_TURN, S_DATA};
    assign tick     = (div_cnt == DIV_LAST);
    assign rise     = shifting & tick & ~sck;
    assign fall     = shifting & tick & sck;
    assign byte_end = fall & (bit_cnt == 3'd7);
    assign accept   = (state == S_IDLE) & bus.req;

    // Sequencing decisions are taken at the SCK fall ending a byte; nxt_byte is
    // the byte loaded into the shifter at that same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        nxt_byte  = 8'hFF;
        go_data   = 1'b0;
        wr_ack_c  = 1'b0;
        case (state)
            S_IDLE: if (bus.req) state_nxt = S_CMD;
            S_CMD: if (byte_end) begin
                state_nxt = S_ADDR;
                cnt_nxt   = '0;
                nxt_byte  = addr_q[23:16];
            end
            S_ADDR: if (byte_end) begin
                if (byte_cnt == ADDR_LAST) begin
                    if (!we_q && TURN > 0) begin
                        state_nxt = S_TURN;
                        cnt_nxt   = '0;
                    end else begin
                        go_data = 1'b1;
                    end
                end else begin
                    cnt_nxt  = byte_cnt + LEN_ONE;
                    nxt_byte = (byte_cnt == '0) ? addr_q[15:8] : addr_q[7:0];
                end
            end
            S_TURN: if (byte_end) begin
                if (byte_cnt == TURN_LAST) go_data = 1'b1;
                else cnt_nxt = byte_cnt + LEN_ONE;
            end
            S_DATA: if (byte_end) begin
                if (byte_cnt == len_q - LEN_ONE) begin
                    state_nxt = S_END;
                end else begin
                    cnt_nxt  = byte_cnt + LEN_ONE;
                    nxt_byte = we_q ? bus.wr_data : 8'hFF;
                    wr_ack_c = we_q;
                end
            end
            S_END: if (tick) state_nxt = S_GAP;
            S_GAP: if (div_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (go_data) begin
            cnt_nxt = '0;
            if (len_q == '0) begin
                state_nxt = S_END;
            end else begin
                state_nxt = S_DATA;
                nxt_byte  = we_q ? bus.wr_data : 8'hFF;
                wr_ack_c  = we_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rd_data_r <= '0;
            rd_vld_r  <= 1'b0;
            done_r    <= 1'b0;
            sck       <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            rd_vld_r <= 1'b0;
            byte_cnt <= cnt_nxt;
            // Half-period timer restarts on every SCK toggle and every phase change.
            if (state == S_IDLE || state_nxt != state || (shifting && tick))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + CW_ONE;

            if (accept) begin
                we_q    <= bus.we;
                len_q   <= bus.len;
                addr_q  <= bus.addr;
                tx_sr   <= bus.cmd;
                mosi    <= bus.we;
                ss      <= 1'b0;
                sck     <= 1'b0;
                bit_cnt <= '0;
            end

            if (rise) begin
                sck   <= 1'b1;
                rx_sr <= {rx_sr[5:0], bus.spi_miso};
                if (state == S_DATA && bit_cnt == 3'd7 && !we_q) begin
                    rd_data_r <= {rx_sr, bus.spi_miso};
                    rd_vld_r  <= 1'b1;
                end
            end

            if (fall) begin
                sck     <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    tx_sr <= nxt_byte[6:0];
                    mosi  <= (state_nxt == S_END) ? 1'b0 : nxt_byte[7];
                end else begin
                    tx_sr <= {tx_sr[5:0], 1'b0};
                    mosi  <= tx_sr[6];
                end
            end

            if (state == S_END && tick) begin
                ss     <= 1'b1;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_r;
    assign bus.wr_ack   = wr_ack_c;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_vld   = rd_vld_r;
    assign bus.spi_sck  = sck;
    assign bus.spi_ss   = ss;
    assign bus.spi_mosi = mosi;
endmodule

// File: tb/tb_pi_master.sv
// Directed bench for pi_master: one CLK_DIV=2 instance for protocol checks plus
// CLK_DIV=1 and CLK_DIV=7 instances for SCK width / MOSI stability checks.
module tb_pi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pi_master_if #(.LEN_W(16)) b0 ();
    pi_master_if #(.LEN_W(16)) b1 ();
    pi_master_if #(.LEN_W(16)) b2 ();

    pi_master #(.CLK_DIV(2), .LEN_W(16), .TURN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    pi_master #(.CLK_DIV(1), .LEN_W(16), .TURN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
    pi_master #(.CLK_DIV(7), .LEN_W(16), .TURN(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    // user-side write data, consumed in order on wr_ack
    logic [7:0] wdata [8] = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    logic [2:0] wr_idx = 3'd0;
    assign b0.wr_data = wdata[wr_idx];
    assign b1.wr_data = 8'hC9;
    assign b2.wr_data = 8'hC9;
    always @(posedge clk) if (b0.wr_ack === 1'b1) wr_idx <= wr_idx + 3'd1;

    // SPI slave model for b0: one bit per SCK period, advanced on SCK fall
    logic [63:0] miso_stream = '0;
    int          miso_pos = 0;
    assign b0.spi_miso = (miso_pos < 64) ? miso_stream[63 - miso_pos] : 1'b0;
    assign b1.spi_miso = 1'b0;
    assign b2.spi_miso = 1'b0;

    logic [2:0] sck_v, ss_v, mosi_v;
    assign sck_v  = {b2.spi_sck, b1.spi_sck, b0.spi_sck};
    assign ss_v   = {b2.spi_ss, b1.spi_ss, b0.spi_ss};
    assign mosi_v = {b2.spi_mosi, b1.spi_mosi, b0.spi_mosi};

    logic [2:0] p_sck = 3'b000, p_ss = 3'b111, p_mosi = 3'b000;
    logic       p_busy = 1'b0;
    int run [3], bad [3], edges [3];
    int cyc = 0, rises = 0, acks = 0, dones = 0, t_ss = 0, t_done = 0, busy_gap = 0;
    logic [7:0] msr = '0;
    logic [7:0] mosi_q [$];
    logic [7:0] rd_q [$];

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 7;
    endfunction

    initial for (int i = 0; i < 3; i++) begin run[i] = 0; bad[i] = 0; edges[i] = 0; end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (ss_v[i] === 1'b0) begin
                if (p_ss[i] === 1'b1) begin
                    run[i] = 1;
                end else if (sck_v[i] !== p_sck[i]) begin
                    edges[i]++;
                    if (run[i] != div_of(i)) bad[i]++;
                    run[i] = 1;
                end else begin
                    run[i]++;
                end
                if (mosi_v[i] !== p_mosi[i] && p_ss[i] !== 1'b1 &&
                    !(p_sck[i] === 1'b1 && sck_v[i] === 1'b0)) bad[i]++;
            end
        end
        if (ss_v[0] === 1'b0 && p_ss[0] === 1'b1) begin
            mosi_q.delete();
            rd_q.delete();
            rises    = 0;
            miso_pos = 0;
        end
        if (ss_v[0] === 1'b0 && sck_v[0] === 1'b1 && p_sck[0] === 1'b0) begin
            rises++;
            msr = {msr[6:0], b0.spi_mosi};
            if (rises % 8 == 0) mosi_q.push_back(msr);
        end
        if (ss_v[0] === 1'b0 && sck_v[0] === 1'b0 && p_sck[0] === 1'b1) miso_pos++;
        if (b0.wr_ack === 1'b1) acks++;
        if (b0.rd_vld === 1'b1) rd_q.push_back(b0.rd_data);
        if (b0.done === 1'b1) begin dones++; t_done = cyc; end
        if (ss_v[0] === 1'b1 && p_ss[0] === 1'b0) t_ss = cyc;
        if (b0.busy === 1'b0 && p_busy === 1'b1) busy_gap = cyc - t_ss;
        p_busy = b0.busy;
        p_sck  = sck_v;
        p_ss   = ss_v;
        p_mosi = mosi_v;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // which=0: MOSI bytes of last transaction, which=1: read bytes; exp MSB-first
    task automatic check_bytes(input string tag, input int which, input int n, input logic [63:0] exp);
        logic [7:0] got;
        check({tag, "_n"}, (which == 0) ? mosi_q.size() : rd_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = 'x;
            if (which == 0 && i < mosi_q.size()) got = mosi_q[i];
            if (which == 1 && i < rd_q.size())   got = rd_q[i];
            check($sformatf("%s[%0d]", tag, i), got, exp[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic start(input logic we, input logic [6:0] cmd, input logic [23:0] addr, input logic [15:0] len);
        b0.we = we; b0.cmd = cmd; b0.addr = addr; b0.len = len; b0.req = 1'b1;
        @(negedge clk);
        b0.req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (b0.busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check(tag, n < 2000, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, n, g, lows;
        b0.req = 0; b0.we = 0; b0.cmd = 0; b0.addr = 0; b0.len = 0;
        b1.req = 0; b1.we = 0; b1.cmd = 0; b1.addr = 0; b1.len = 0;
        b2.req = 0; b2.we = 0; b2.cmd = 0; b2.addr = 0; b2.len = 0;
        repeat (3) @(negedge clk);
        check("rst_ss", b0.spi_ss, 1);
        check("rst_sck", b0.spi_sck, 0);
        check("rst_mosi", b0.spi_mosi, 0);
        check("rst_busy", b0.busy, 0);
        check("rst_done", b0.done, 0);
        check("rst_wr_ack", b0.wr_ack, 0);
        check("rst_rd_vld", b0.rd_vld, 0);
        check("rst_rd_data", b0.rd_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write len=2
        d0 = dones; a0 = acks;
        start(1'b1, 7'h05, 24'h123456, 16'd2);
        check("t1_busy", b0.busy, 1);
        check("t1_ss", b0.spi_ss, 0);
        check("t1_mosi0", b0.spi_mosi, 1);
        wait_idle("t1_timeout");
        check_bytes("t1_mosi", 0, 6, 64'h0000_8512_3456_A55A);
        check("t1_rises", rises, 48);
        check("t1_acks", acks - a0, 2);
        check("t1_done", dones - d0, 1);
        check("t1_rdvld", rd_q.size(), 0);
        check("t1_busy_gap", busy_gap, 4);
        check("t1_done_at_ss", t_done, t_ss);

        // 2: read len=3 with one turnaround byte
        miso_stream = {40'h0, 24'h3CC3FF};
        d0 = dones; a0 = acks;
        start(1'b0, 7'h05, 24'hABCDEF, 16'd3);
        wait_idle("t2_timeout");
        check_bytes("t2_mosi", 0, 8, 64'h05AB_CDEF_FFFF_FFFF);
        check_bytes("t2_rd", 1, 3, 64'h0000_0000_003C_C3FF);
        check("t2_rises", rises, 64);
        check("t2_acks", acks - a0, 0);
        check("t2_done", dones - d0, 1);

        // 3: header-only write
        d0 = dones; a0 = acks;
        start(1'b1, 7'h7F, 24'h000001, 16'd0);
        wait_idle("t3_timeout");
        check_bytes("t3_mosi", 0, 4, 64'h0000_0000_FF00_0001);
        check("t3_rises", rises, 32);
        check("t3_acks", acks - a0, 0);
        check("t3_rdvld", rd_q.size(), 0);
        check("t3_done", dones - d0, 1);

        // 4: req held high and re-pulsed mid-DATA
        d0 = dones; a0 = acks;
        b0.we = 1'b1; b0.cmd = 7'h2A; b0.addr = 24'h0A0B0C; b0.len = 16'd2; b0.req = 1'b1;
        @(negedge clk);
        check("t4_busy", b0.busy, 1);
        n = 0;
        while (b0.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 140) b0.req = 1'b0;
            if (n == 141) b0.req = 1'b1;
        end
        check("t4_done_timeout", n < 2000, 1'b1);
        g = 0; lows = 0;
        while (b0.busy === 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
            if (b0.spi_ss === 1'b0) lows++;
        end
        check("t4_gap_len", g, 4);
        check("t4_gap_ss_low", lows, 0);
        @(negedge clk);
        check("t4_next_busy", b0.busy, 1);
        check("t4_next_ss", b0.spi_ss, 0);
        b0.req = 1'b0;
        wait_idle("t4_timeout");
        check("t4_done", dones - d0, 2);
        check("t4_acks", acks - a0, 4);
        check_bytes("t4_mosi", 0, 6, 64'h0000_AA0A_0B0C_3344);

        // 5: reset during ADDR
        d0 = dones;
        start(1'b1, 7'h11, 24'hFEDCBA, 16'd1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_ss", b0.spi_ss, 1);
        check("t5_sck", b0.spi_sck, 0);
        check("t5_busy", b0.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_done", dones - d0, 0);
        start(1'b1, 7'h11, 24'hFEDCBA, 16'd1);
        wait_idle("t5_timeout");
        check_bytes("t5_mosi", 0, 5, 64'h0000_0091_FEDC_BA66);
        check("t5_rises", rises, 40);
        check("t5_done", dones - d0, 1);

        // 6: CLK_DIV=1 and CLK_DIV=7 timing
        b1.we = 1'b1; b1.cmd = 7'h01; b1.addr = 24'h000000; b1.len = 16'd1; b1.req = 1'b1;
        b2.we = 1'b1; b2.cmd = 7'h01; b2.addr = 24'h000000; b2.len = 16'd1; b2.req = 1'b1;
        @(negedge clk);
        b1.req = 1'b0; b2.req = 1'b0;
        n = 0;
        while ((b1.busy === 1'b1 || b2.busy === 1'b1) && n < 3000) begin @(negedge clk); n++; end
        check("t6_timeout", n < 3000, 1'b1);
        @(negedge clk);
        check("t6_edges_div1", edges[1], 80);
        check("t6_edges_div7", edges[2], 80);
        check("t6_bad_div1", bad[1], 0);
        check("t6_bad_div7", bad[2], 0);
        check("t6_bad_div2", bad[0], 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
